// File: rtl/axi4_read_verify_sequence_if.sv
// -----------------------------------------------------------------------------
// axi4_read_verify_sequence_if
// AXI4 read-address and read-data channel bundle between the read-back checker
// (master modport) and the memory-side slave (slave modport).
// Signals:
//   o_arid/o_araddr/o_arlen/o_arsize/o_arburst/o_arvalid : AR channel, master out
//   i_arready                                            : AR ready, slave out
//   i_rid/i_rdata/i_rresp/i_rlast/i_rvalid               : R channel, slave out
//   o_rready                                             : R ready, master out
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface axi4_read_verify_sequence_if #(
  parameter int pAxi4BusWidth = 512
);
  logic [5:0]               o_arid;
  logic [32:0]              o_araddr;
  logic [7:0]               o_arlen;
  logic [2:0]               o_arsize;
  logic [1:0]               o_arburst;
  logic                     o_arvalid;
  logic                     i_arready;
  logic [5:0]               i_rid;
  logic [pAxi4BusWidth-1:0] i_rdata;
  logic [1:0]               i_rresp;
  logic                     i_rlast;
  logic                     i_rvalid;
  logic                     o_rready;

  modport master (
    output o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid, o_rready,
    input  i_arready, i_rid, i_rdata, i_rresp, i_rlast, i_rvalid
  );

  modport slave (
    input  o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid, o_rready,
    output i_arready, i_rid, i_rdata, i_rresp, i_rlast, i_rvalid
  );
endinterface

// File: rtl/axi4_read_verify_sequence.sv
// -----------------------------------------------------------------------------
// axi4_read_verify_sequence
// Read-back checker for the LPDDR4 memory test. Every write-done pulse on
// i_start queues one AXI4 INCR read of the next burst address; returned beats
// are compared lane-by-lane against the regenerated write pattern.
// Ports:
//   iCLK, iRST     : clock, asynchronous active-low reset
//   i_start        : one-cycle pulse per completed write burst
//   bus            : AXI4 AR/R channels (master modport)
//   o_rdone        : one-cycle pulse per verified burst
//   o_beat_err     : one-cycle pulse per failing beat
//   o_fail         : sticky, any error since reset
//   o_err_cnt      : failing-beat count, saturating
//   o_pend_ovf     : sticky, a start request was lost
//   o_rspeed_ave   : moving average of read latency (AXI4_RSPEED_MEAS_EN)
// Optional feature macro: AXI4_RSPEED_MEAS_EN (latency measurement). When
// undefined, o_rspeed_ave is tied to zero.
//
// state    | meaning
// ST_IDLE  | waiting for a pending start request
// ST_AR    | read address presented, waiting for arready
// ST_R     | collecting and checking the burst beats
// ST_DONE  | one-cycle gap after the final beat
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module axi4_read_verify_sequence #(
  parameter int          pAxi4BusWidth = 512,
  parameter int          pDataBitWidth = 16,
  parameter int          pDdrBurstSize = 16,
  parameter logic [32:0] pAdrsLimit    = 33'h1_0000_0000
) (
  input  logic                                 iCLK,
  input  logic                                 iRST,
  input  logic                                 i_start,
  axi4_read_verify_sequence_if.master          bus,
  output logic                                 o_rdone,
  output logic                                 o_beat_err,
  output logic                                 o_fail,
  output logic [15:0]                          o_err_cnt,
  output logic                                 o_pend_ovf,
  output logic [7:0]                           o_rspeed_ave
);

  localparam int          NLANE       = pAxi4BusWidth / pDataBitWidth;
  localparam int          BCW         = (pDdrBurstSize > 2) ? $clog2(pDdrBurstSize) : 1;
  localparam logic [33:0] BURST_BYTES = 34'(pDdrBurstSize * pAxi4BusWidth / 8);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(pDdrBurstSize - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DONE} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                pend_q, pend_d;
  logic                      pend_ovf_q, pend_ovf_d;
  logic [32:0]               araddr_q, araddr_d;
  logic [BCW-1:0]            beat_q, beat_d;
  logic [pDataBitWidth-1:0]  e_q [NLANE];
  logic [pDataBitWidth-1:0]  e_d [NLANE];
  logic                      rdone_q, beat_err_q, fail_q;
  logic [15:0]               err_cnt_q;

  logic        arvalid, rready;
  logic        ar_acc, beat_acc, last_beat, lane_mis, beat_bad;
  logic [33:0] addr_sum;

  assign ar_acc    = arvalid & bus.i_arready;
  assign beat_acc  = rready & bus.i_rvalid;
  assign last_beat = (beat_q == LAST_BEAT);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pend_q != 3'd0) state_d = ST_AR;
      ST_AR:   if (ar_acc) state_d = ST_R;
      ST_R:    if (beat_acc && last_beat) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    arvalid = 1'b0;
    rready  = 1'b0;
    case (state_q)
      ST_AR:   arvalid = 1'b1;
      ST_R:    rready  = 1'b1;
      default: ;
    endcase
  end

  // ---------------- pending start queue ----------------
  always_comb begin
    pend_d     = pend_q;
    pend_ovf_d = pend_ovf_q;
    if (i_start && !ar_acc) begin
      if (pend_q == 3'd7) pend_ovf_d = 1'b1;
      else                pend_d     = pend_q + 3'd1;
    end else if (!i_start && ar_acc) begin
      pend_d = pend_q - 3'd1;
    end
  end

  // ---------------- address / beat counter ----------------
  assign addr_sum = {1'b0, araddr_q} + BURST_BYTES;

  always_comb begin
    araddr_d = araddr_q;
    if (ar_acc) araddr_d = (addr_sum >= {1'b0, pAdrsLimit}) ? 33'd0 : addr_sum[32:0];
    beat_d = beat_q;
    if (beat_acc) beat_d = last_beat ? '0 : beat_q + BCW'(1);
  end

  // ---------------- expected pattern and compare ----------------
  always_comb begin
    lane_mis = 1'b0;
    for (int x = 0; x < NLANE; x++) begin
      if (bus.i_rdata[x*pDataBitWidth +: pDataBitWidth] != e_q[x]) lane_mis = 1'b1;
      e_d[x] = e_q[x];
      if (beat_acc) begin
        if (x < pDdrBurstSize) e_d[x] = e_q[x] + pDataBitWidth'(pDdrBurstSize);
        else                   e_d[x] = pDataBitWidth'(16'h1289);
      end
    end
  end

  // rlast must be asserted exactly on the final beat
  assign beat_bad = lane_mis | (bus.i_rresp != 2'b00) | (bus.i_rid != 6'd0) |
                    (bus.i_rlast != last_beat);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      pend_q     <= 3'd0;
      pend_ovf_q <= 1'b0;
      araddr_q   <= 33'd0;
      beat_q     <= '0;
      rdone_q    <= 1'b0;
      beat_err_q <= 1'b0;
      fail_q     <= 1'b0;
      err_cnt_q  <= 16'd0;
      for (int x = 0; x < NLANE; x++) e_q[x] <= pDataBitWidth'(x);
    end else begin
      pend_q     <= pend_d;
      pend_ovf_q <= pend_ovf_d;
      araddr_q   <= araddr_d;
      beat_q     <= beat_d;
      e_q        <= e_d;
      rdone_q    <= beat_acc & last_beat;
      beat_err_q <= beat_acc & beat_bad;
      if (beat_acc && beat_bad) begin
        fail_q <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  // ---------------- read latency measurement ----------------
`ifdef AXI4_RSPEED_MEAS_EN
  logic [7:0]  lat_q;
  logic [7:0]  lat_next;
  logic [7:0]  ring_q [8];
  logic [2:0]  wp_q;
  logic [10:0] ring_sum;
  logic [7:0]  ave_q;

  assign lat_next = (lat_q == 8'hFF) ? 8'hFF : lat_q + 8'd1;

  always_comb begin
    ring_sum = 11'd0;
    for (int i = 0; i < 8; i++) ring_sum = ring_sum + 11'(ring_q[i]);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      lat_q <= 8'd0;
      wp_q  <= 3'd0;
      ave_q <= 8'd0;
      for (int i = 0; i < 8; i++) ring_q[i] <= 8'd0;
    end else begin
      if (state_q == ST_AR || state_q == ST_R) lat_q <= lat_next;
      else                                     lat_q <= 8'd0;
      if (beat_acc && last_beat) begin
        ring_q[wp_q] <= lat_next;
        wp_q         <= wp_q + 3'd1;
      end
      if (rdone_q) ave_q <= ring_sum[10:3];
    end
  end

  assign o_rspeed_ave = ave_q;
`else
  assign o_rspeed_ave = 8'd0;
`endif

  // ---------------- outputs ----------------
  assign bus.o_arid    = 6'd0;
  assign bus.o_araddr  = araddr_q;
  assign bus.o_arlen   = 8'(pDdrBurstSize - 1);
  assign bus.o_arsize  = (pAxi4BusWidth == 512) ? 3'b110 : 3'b101;
  assign bus.o_arburst = 2'b01;
  assign bus.o_arvalid = arvalid;
  assign bus.o_rready  = rready;

  assign o_rdone    = rdone_q;
  assign o_beat_err = beat_err_q;
  assign o_fail     = fail_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_pend_ovf = pend_ovf_q;

endmodule

// File: tb/tb_axi4_read_verify_sequence.sv
`timescale 1ns/1ps
module tb_axi4_read_verify_sequence;

  localparam int          W     = 512;
  localparam int          DW    = 16;
  localparam int          BS    = 16;
  localparam logic [32:0] LIMIT = 33'h1000;
  localparam int          NL    = W / DW;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        i_start = 1'b0;
  logic        o_rdone, o_beat_err, o_fail, o_pend_ovf;
  logic [15:0] o_err_cnt;
  logic [7:0]  o_rspeed_ave;

  axi4_read_verify_sequence_if #(.pAxi4BusWidth(W)) bus ();

  axi4_read_verify_sequence #(
    .pAxi4BusWidth(W), .pDataBitWidth(DW), .pDdrBurstSize(BS), .pAdrsLimit(LIMIT)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .i_start(i_start), .bus(bus),
    .o_rdone(o_rdone), .o_beat_err(o_beat_err), .o_fail(o_fail),
    .o_err_cnt(o_err_cnt), .o_pend_ovf(o_pend_ovf), .o_rspeed_ave(o_rspeed_ave)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          beats_m = 0;   // beats accepted since reset
  int          err_m   = 0;
  logic [32:0] addr_m  = 33'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pattern as a closed form: lanes below the burst size step by BS per beat,
  // upper lanes hold their index until the first beat, then 0x1289.
  function automatic logic [15:0] exp_lane(input int x);
    if (x < BS) return 16'(x + BS * beats_m);
    return (beats_m == 0) ? 16'(x) : 16'h1289;
  endfunction

  task automatic pulse_start(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iCLK) i_start = 1'b1;
    end
    @(negedge iCLK) i_start = 1'b0;
  endtask

  // Serves one AR + R transaction as the slave. Negative beat indices disable
  // the corresponding fault. rst_beat aborts the burst with a reset.
  task automatic run_burst(input int ar_dly, input int bad_beat, input int bad_lane,
                           input int resp_beat, input int early_last, input int rid_beat,
                           input bit gaps, input int rst_beat);
    int   waited;
    logic [W-1:0] d;
    bit   bad;
    waited = 0;
    while (bus.o_arvalid !== 1'b1 && waited < 100) begin
      @(negedge iCLK);
      waited++;
    end
    check("arvalid_timeout", 64'(bus.o_arvalid), 64'd1);
    check("araddr", 64'(bus.o_araddr), 64'(addr_m));
    check("arlen", 64'(bus.o_arlen), 64'(BS - 1));
    check("arsize_burst_id", {49'd0, bus.o_arsize, bus.o_arburst, bus.o_arid}, {49'd0, 3'b110, 2'b01, 6'd0});
    for (int i = 0; i < ar_dly; i++) begin
      @(negedge iCLK);
      check("ar_hold", {30'd0, bus.o_arvalid, bus.o_araddr}, {30'd0, 1'b1, addr_m});
    end
    bus.i_arready = 1'b1;
    @(negedge iCLK);
    bus.i_arready = 1'b0;
    check("arvalid_drop", 64'(bus.o_arvalid), 64'd0);
    addr_m = ((addr_m + 33'h400) >= LIMIT) ? 33'd0 : addr_m + 33'h400;

    for (int b = 0; b < BS; b++) begin
      if (gaps) begin
        int k;
        k = $urandom_range(0, 2);
        for (int g = 0; g < k; g++) begin
          @(negedge iCLK);
          check("gap_rready", {62'd0, bus.o_rready, o_beat_err}, {62'd0, 1'b1, 1'b0});
        end
      end
      if (b == rst_beat) begin
        iRST = 1'b0;
        #1;
        return;
      end
      for (int x = 0; x < NL; x++) d[x*DW +: DW] = exp_lane(x);
      if (b == bad_beat) d[bad_lane*DW +: DW] = d[bad_lane*DW +: DW] ^ 16'h8001;
      bus.i_rdata  = d;
      bus.i_rresp  = (b == resp_beat) ? 2'b10 : 2'b00;
      bus.i_rid    = (b == rid_beat) ? 6'd5 : 6'd0;
      bus.i_rlast  = (b == BS - 1) || (b == early_last);
      bus.i_rvalid = 1'b1;
      check("rready", 64'(bus.o_rready), 64'd1);
      @(negedge iCLK);
      bus.i_rvalid = 1'b0;
      bus.i_rlast  = 1'b0;
      bad = (b == bad_beat) || (b == resp_beat) || (b == early_last) || (b == rid_beat);
      beats_m++;
      if (bad && err_m < 16'hFFFF) err_m++;
      check("beat_err", 64'(o_beat_err), 64'(bad));
      check("err_cnt", 64'(o_err_cnt), 64'(err_m));
      check("fail", 64'(o_fail), 64'(err_m != 0));
      check("rdone", 64'(o_rdone), 64'(b == BS - 1));
    end
    check("rready_done", 64'(bus.o_rready), 64'd0);
    @(negedge iCLK);
    check("rdone_pulse_end", {62'd0, o_rdone, o_beat_err}, 64'd0);
    check("rspeed_ave", 64'(o_rspeed_ave), 64'd0);
  endtask

  initial begin
    bus.i_arready = 1'b0;
    bus.i_rid     = 6'd0;
    bus.i_rdata   = '0;
    bus.i_rresp   = 2'b00;
    bus.i_rlast   = 1'b0;
    bus.i_rvalid  = 1'b0;

    // reset state
    repeat (3) @(negedge iCLK);
    check("rst_araddr", 64'(bus.o_araddr), 64'd0);
    check("rst_valid_ready", {62'd0, bus.o_arvalid, bus.o_rready}, 64'd0);
    check("rst_status", {59'd0, o_rdone, o_beat_err, o_fail, o_pend_ovf, 1'b0}, 64'd0);
    check("rst_err_cnt", 64'(o_err_cnt), 64'd0);
    check("rst_const", {51'd0, bus.o_arlen, bus.o_arsize, bus.o_arburst}, {51'd0, 8'd15, 3'b110, 2'b01});
    iRST = 1'b1;

    // single clean burst
    pulse_start(1);
    run_burst(1, -1, 0, -1, -1, -1, 1'b0, -1);

    // three back-to-back bursts
    pulse_start(3);
    for (int i = 0; i < 3; i++) run_burst($urandom_range(0, 3), -1, 0, -1, -1, -1, 1'b1, -1);

    // lane 3 of beat 5 corrupted, then clean bursts keep fail sticky
    pulse_start(3);
    run_burst(0, 5, 3, -1, -1, -1, 1'b0, -1);
    run_burst(2, -1, 0, -1, -1, -1, 1'b1, -1);
    run_burst(1, -1, 0, -1, -1, -1, 1'b0, -1);

    // bad response on beat 0 and early rlast on beat 14
    pulse_start(1);
    run_burst(0, -1, 0, 0, 14, -1, 1'b0, -1);

    // pending overflow with arready held low
    check("pend_ovf_before", 64'(o_pend_ovf), 64'd0);
    pulse_start(9);
    @(negedge iCLK);
    check("pend_ovf_set", 64'(o_pend_ovf), 64'd1);
    for (int i = 0; i < 7; i++) run_burst($urandom_range(0, 2), -1, 0, -1, -1, -1, 1'b1, -1);
    begin
      int extra;
      extra = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge iCLK);
        if (bus.o_arvalid === 1'b1) extra++;
      end
      check("no_eighth_burst", 64'(extra), 64'd0);
    end
    check("pend_ovf_sticky", 64'(o_pend_ovf), 64'd1);

    // randomized bursts with random fault placement
    for (int n = 0; n < 6; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      pulse_start(1);
      run_burst($urandom_range(0, 3),
                (kind == 1) ? int'($urandom_range(0, BS - 1)) : -1,
                $urandom_range(0, NL - 1),
                (kind == 2) ? int'($urandom_range(0, BS - 1)) : -1,
                -1,
                (kind == 3) ? int'($urandom_range(0, BS - 1)) : -1,
                1'b1, -1);
    end

    // reset during beat 8
    pulse_start(1);
    run_burst(0, -1, 0, -1, -1, -1, 1'b0, 8);
    beats_m = 0;
    err_m   = 0;
    addr_m  = 33'd0;
    check("midrst_bus", {29'd0, bus.o_arvalid, bus.o_rready, bus.o_araddr}, 64'd0);
    check("midrst_status", {60'd0, o_rdone, o_beat_err, o_fail, o_pend_ovf}, 64'd0);
    check("midrst_err_cnt", 64'(o_err_cnt), 64'd0);
    @(negedge iCLK) iRST = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge iCLK);
        if (o_rdone === 1'b1 || bus.o_arvalid === 1'b1) seen++;
      end
      check("midrst_quiet", 64'(seen), 64'd0);
    end

    // fresh pattern and address after reset
    pulse_start(1);
    run_burst(1, -1, 0, -1, -1, -1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
